// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store unit bridging the execute stage to a
// handshaked, variable-latency data memory port. Handles byte/half/word(/double)
// lanes, sign/zero extension, misaligned and illegal-op traps, and a timeout.
module lsu_mem_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_base,
  input  logic [XLEN-1:0]   i_offset,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_done,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_trap,
  output logic [1:0]        o_cause,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_valid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsuState_t;

  lsuState_t         r_state;
  lsuState_t         w_nextState;

  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic [1:0]        r_sizeLog;
  logic              r_unsigned;
  logic              r_isLoad;
  logic [1:0]        r_cause;
  logic [CW-1:0]     r_count;

  logic [XLEN-1:0]   w_addr;
  logic [1:0]        w_sizeLog;
  logic [OB-1:0]     w_alignMask;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_trapReq;

  logic              w_accept;
  logic              w_capture;
  logic              w_timeout;
  logic              w_toHit;
  logic              w_issue;
  logic              w_resp;

  logic [OB-1:0]     w_off;
  logic [NB-1:0]     w_lenMask;
  logic [XLEN-1:0]   w_sh;
  logic [6:0]        w_s;
  logic [XLEN-1:0]   w_up;
  logic signed [XLEN-1:0] w_upS;
  logic [XLEN-1:0]   w_sext;
  logic [XLEN-1:0]   w_ext;

  // Request decode straight off the core inputs, used only in the accept cycle.
  // funct3[1:0] is log2 of the access size; funct3[2] selects zero extension.
  assign w_addr      = i_base + i_offset;
  assign w_sizeLog   = i_funct3[1:0];
  assign w_alignMask = OB'((4'd1 << w_sizeLog) - 4'd1);
  assign w_illegal   = (i_load == i_store)
                    || (i_store && i_funct3[2])
                    || (i_funct3 == 3'b111)
                    || ((XLEN == 32) && ((i_funct3 == 3'b011) || (i_funct3 == 3'b110)));
  assign w_misaligned = (w_addr[OB-1:0] & w_alignMask) != '0;
  assign w_trapReq    = w_illegal || w_misaligned;

  // Timeout fires when the counter sits at TIMEOUT-1 in ISSUE/WAIT; 0 disables it.
  assign w_toHit = (TIMEOUT != 0) && (r_count == CW'(TIMEOUT - 1));

  assign w_issue = (r_state == ISSUE);
  assign w_resp  = (r_state == RESP);

  // Memory-side outputs are derived from state so reset drops strobes at once;
  // address, mask and data are held at zero outside ISSUE.
  assign w_off       = r_addr[OB-1:0];
  assign w_lenMask   = NB'((9'd1 << (4'd1 << r_sizeLog)) - 9'd1);
  assign o_mem_ren   = w_issue && r_isLoad;
  assign o_mem_wen   = w_issue && !r_isLoad;
  assign o_mem_addr  = w_issue ? {r_addr[XLEN-1:OB], {OB{1'b0}}} : '0;
  assign o_mem_mask  = w_issue ? NB'(w_lenMask << w_off) : '0;
  assign o_mem_wdata = w_issue ? (r_wdata << {w_off, 3'b000}) : '0;

  assign o_ready = (r_state == IDLE);
  assign o_done  = w_resp;
  assign o_trap  = w_resp && (r_cause != CAUSE_NONE);
  assign o_cause = w_resp ? r_cause : CAUSE_NONE;
  assign o_rdata = r_rdata;

  // Load extension: shift the addressed lane down, push it to the top, then shift
  // back arithmetically (signed) or logically (unsigned) to extend.
  always_comb begin
    w_sh   = i_mem_rdata >> {w_off, 3'b000};
    w_s    = 7'(XLEN) - (7'd8 << r_sizeLog);
    w_up   = w_sh << w_s;
    w_upS  = w_up;
    w_sext = w_upS >>> w_s;
    w_ext  = r_unsigned ? (w_up >> w_s) : w_sext;
  end

  // State register; asynchronous reset aborts any transaction in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic plus the one-cycle strobes that steer the datapath.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_accept    = 1'b1;
          w_nextState = w_trapReq ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ready && i_mem_valid) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end else if (w_toHit) begin
          w_timeout   = 1'b1;
          w_nextState = RESP;
        end else if (i_mem_ready) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_valid) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end else if (w_toHit) begin
          w_timeout   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand latch, result capture, trap cause and timeout counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_sizeLog  <= '0;
      r_unsigned <= 1'b0;
      r_isLoad   <= 1'b0;
      r_cause    <= CAUSE_NONE;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= w_addr;
        r_wdata    <= i_wdata;
        r_sizeLog  <= w_sizeLog;
        r_unsigned <= i_funct3[2];
        r_isLoad   <= i_load;
        r_rdata    <= '0;
        r_count    <= '0;
        if (w_illegal)         r_cause <= CAUSE_ILLEGAL;
        else if (w_misaligned) r_cause <= CAUSE_MISALIGN;
        else                   r_cause <= CAUSE_NONE;
      end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
        r_count <= r_count + CW'(1);
      end
      if (w_capture) begin
        r_rdata <= r_isLoad ? w_ext : '0;
        r_cause <= CAUSE_NONE;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_cause <= CAUSE_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized transactions against a transaction-level
// model of the load/store unit (XLEN=32, TIMEOUT=8).
module tb_lsu_mem_ctrl;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid, load, store;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   base, offset, wdata;
  logic              ready, done, trap;
  logic [XLEN-1:0]   rdata;
  logic [1:0]        cause;
  logic [XLEN-1:0]   memAddr, memWdata, memRdata;
  logic              memRen, memWen, memReady, memValid;
  logic [XLEN/8-1:0] memMask;

  int vecCount = 0;
  int errCount = 0;

  lsu_mem_ctrl #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_load(load), .i_store(store), .i_funct3(funct3),
    .i_base(base), .i_offset(offset), .i_wdata(wdata),
    .o_done(done), .o_rdata(rdata), .o_trap(trap), .o_cause(cause),
    .o_mem_addr(memAddr), .o_mem_ren(memRen), .o_mem_wen(memWen),
    .o_mem_wdata(memWdata), .o_mem_mask(memMask),
    .i_mem_ready(memReady), .i_mem_valid(memValid), .i_mem_rdata(memRdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: size in bytes from funct3 and the trap cause for a request.
  function automatic int sizeBytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int modelCause(input bit ld, input bit st, input logic [2:0] f3,
                                    input logic [31:0] addr);
    bit illegal;
    illegal = (ld == st) || (st && f3[2]) || (f3 == 3'd7) || (f3 == 3'd3) || (f3 == 3'd6);
    if (illegal) return 2;
    if ((addr % sizeBytes(f3)) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
    longint unsigned v, m;
    int nb;
    nb = sizeBytes(f3);
    m  = (64'd1 << (8 * nb)) - 1;
    v  = (longint'(word) >> (8 * (addr % 4))) & m;
    if (!f3[2] && v[8*nb-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // One transaction: memory raises ready in cycle kr and valid in cycle kv
  // (cycles counted from 1 after the accept edge).
  task automatic applyStimulus(input string nm, input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                               input int kr, input int kv, input logic [31:0] word);
    logic [31:0] addr, expR;
    int c, endK, off, nb;
    bit timedOut, inIssue;
    @(negedge clk);
    checkOutput({nm, ".readyIdle"}, ready, 1);
    valid = 1; load = ld; store = st; funct3 = f3; base = b; offset = o; wdata = wd;
    memRdata = word; memReady = 0; memValid = 0;
    @(negedge clk);
    valid = 0;
    addr = b + o;
    c = modelCause(ld, st, f3, addr);
    if (c != 0) begin
      checkOutput({nm, ".trapDone"}, done, 1);
      checkOutput({nm, ".trapFlag"}, trap, 1);
      checkOutput({nm, ".trapCause"}, cause, c);
      checkOutput({nm, ".trapRdata"}, rdata, 0);
      checkOutput({nm, ".trapStrobe"}, {memRen, memWen}, 0);
    end else begin
      timedOut = kv > TO;
      endK = timedOut ? TO : kv;
      off = addr % 4;
      nb = sizeBytes(f3);
      for (int k = 1; k <= endK; k++) begin
        inIssue = (k <= kr);
        checkOutput({nm, ".ren"}, memRen, ld && inIssue);
        checkOutput({nm, ".wen"}, memWen, st && inIssue);
        checkOutput({nm, ".notDone"}, done, 0);
        if (inIssue) begin
          checkOutput({nm, ".addr"}, memAddr, addr & 32'hFFFF_FFFC);
          checkOutput({nm, ".mask"}, memMask, ((1 << nb) - 1) << off);
          if (st) checkOutput({nm, ".wdata"}, memWdata, 32'(64'(wd) << (8 * off)));
        end
        memReady = (k == kr);
        memValid = (k == kv);
        @(negedge clk);
      end
      memReady = 0; memValid = 0;
      expR = (ld && !timedOut) ? modelLoad(f3, addr, word) : 32'd0;
      checkOutput({nm, ".done"}, done, 1);
      checkOutput({nm, ".trap"}, trap, timedOut);
      checkOutput({nm, ".cause"}, cause, timedOut ? 3 : 0);
      checkOutput({nm, ".rdata"}, rdata, expR);
      checkOutput({nm, ".strobeOff"}, {memRen, memWen}, 0);
    end
    @(negedge clk);
    checkOutput({nm, ".doneOnce"}, done, 0);
    checkOutput({nm, ".readyAgain"}, ready, 1);
  endtask

  // Load that is aborted by reset in cycle kReset; a late memory valid must be ignored.
  task automatic resetDuring(input string nm, input int kr, input int kReset);
    @(negedge clk);
    valid = 1; load = 1; store = 0; funct3 = 3'd2; base = 32'h5000; offset = 0;
    memReady = 0; memValid = 0;
    @(negedge clk);
    valid = 0;
    for (int k = 1; k < kReset; k++) begin
      memReady = (k == kr);
      @(negedge clk);
    end
    memReady = 0;
    checkOutput({nm, ".renBefore"}, memRen, kReset <= kr);
    rst = 1;
    #1;
    checkOutput({nm, ".renAsync"}, memRen, 0);
    checkOutput({nm, ".wenAsync"}, memWen, 0);
    checkOutput({nm, ".readyAsync"}, ready, 1);
    checkOutput({nm, ".doneAsync"}, done, 0);
    @(negedge clk);
    rst = 0;
    memValid = 1;
    @(negedge clk);
    memValid = 0;
    for (int k = 0; k < 3; k++) begin
      checkOutput({nm, ".noDone"}, done, 0);
      checkOutput({nm, ".idle"}, ready, 1);
      @(negedge clk);
    end
  endtask

  // Main sequence: reset values, the directed plan, boundaries, then random traffic.
  initial begin
    bit ld;
    logic [2:0] f3;
    int kr, kv, so;
    rst = 1; valid = 0; load = 0; store = 0; funct3 = 0;
    base = 0; offset = 0; wdata = 0; memReady = 0; memValid = 0; memRdata = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checkOutput("rst.ready", ready, 1);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.trap", trap, 0);
    checkOutput("rst.cause", cause, 0);
    checkOutput("rst.rdata", rdata, 0);
    checkOutput("rst.strobes", {memRen, memWen}, 0);
    checkOutput("rst.addr", memAddr, 0);
    checkOutput("rst.wdata", memWdata, 0);
    checkOutput("rst.mask", memMask, 0);

    applyStimulus("sb",  0, 1, 3'd0, 32'h2000, 32'd3, 32'h0000_00AB, 1, 1, 32'h0);
    applyStimulus("lh",  1, 0, 3'd1, 32'h1000, 32'd2, 32'h0, 1, 1, 32'h80FF_1234);
    applyStimulus("lhu", 1, 0, 3'd5, 32'h1000, 32'd2, 32'h0, 1, 1, 32'h80FF_1234);
    applyStimulus("lb",  1, 0, 3'd0, 32'h1000, 32'd1, 32'h0, 1, 1, 32'h80FF_1234);
    applyStimulus("lbN", 1, 0, 3'd0, 32'h1000, 32'd3, 32'h0, 1, 2, 32'h80FF_1234);
    applyStimulus("lwMis", 1, 0, 3'd2, 32'h1000, 32'd1, 32'h0, 1, 1, 32'h0);
    applyStimulus("ld32",  1, 0, 3'd3, 32'h1000, 32'd0, 32'h0, 1, 1, 32'h0);
    applyStimulus("shIll", 0, 1, 3'd5, 32'h1000, 32'd0, 32'h0, 1, 1, 32'h0);
    applyStimulus("both",  1, 1, 3'd2, 32'h1000, 32'd0, 32'h0, 1, 1, 32'h0);
    applyStimulus("swStall", 0, 1, 3'd2, 32'h3000, 32'd0, 32'hDEAD_BEEF, 4, 6, 32'h0);
    applyStimulus("lwTo",  1, 0, 3'd2, 32'h4000, 32'd0, 32'h0, 1, 1000, 32'h0);
    applyStimulus("lwEdge", 1, 0, 3'd2, 32'h4000, 32'd0, 32'h0, 1, TO, 32'h1234_5678);
    applyStimulus("lwPast", 1, 0, 3'd2, 32'h4000, 32'd0, 32'h0, 1, TO + 1, 32'h1234_5678);
    applyStimulus("swTo",  0, 1, 3'd2, 32'h4000, 32'd0, 32'h1, 1000, 1000, 32'h0);

    resetDuring("rstWait", 1, 3);
    applyStimulus("afterRst", 1, 0, 3'd2, 32'h6000, 32'd4, 32'h0, 1, 1, 32'hCAFE_F00D);
    resetDuring("rstIssue", 100, 2);

    for (int i = 0; i < 150; i++) begin
      ld = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      kr = $urandom_range(1, 4);
      kv = ($urandom_range(0, 9) == 0) ? 1000 : kr + $urandom_range(0, 3);
      so = $urandom_range(0, 16) - 8;
      if ($urandom_range(0, 19) == 0)
        applyStimulus("rndLs", 1, ld, f3, $urandom, 32'(so), $urandom, kr, kv, $urandom);
      else
        applyStimulus("rnd", ld, !ld, f3, $urandom, 32'(so), $urandom, kr, kv, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
